// File: rtl/inst_prefetch_queue.sv
// Sequential instruction prefetch FIFO between instruction memory and decode.
// Ports: clk, reset (async, active-high), enable, mem_addr/mem_inst to memory,
// flush/flush_pc redirect, inst_out/inst_pc/inst_valid/inst_ready to the CPU, level.
module inst_prefetch_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  output logic [ADDR_W-1:0]          mem_addr,
  input  logic [DATA_W-1:0]          mem_inst,
  input  logic                       flush,
  input  logic [ADDR_W-1:0]          flush_pc,
  output logic [DATA_W-1:0]          inst_out,
  output logic [ADDR_W-1:0]          inst_pc,
  output logic                       inst_valid,
  input  logic                       inst_ready,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [DATA_W-1:0] word_q [DEPTH];
  logic [ADDR_W-1:0] pc_q   [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [LW-1:0]     level_q;
  logic [LW-1:0]     level_d;
  logic [ADDR_W-1:0] fetch_pc;

  logic push;
  logic pop;

  assign inst_valid = (level_q != '0);

  // A full queue may still accept a word when the head leaves the
  // same cycle; flush overrides both sides of the handshake.
  assign pop  = inst_valid && inst_ready && !flush;
  assign push = enable && !flush && ((level_q < FULL) || pop);

  always_comb begin
    level_d = level_q;
    unique case (1'b1)
      flush:          level_d = '0;
      push && !pop:   level_d = level_q + LW'(1);
      pop  && !push:  level_d = level_q - LW'(1);
      default:        level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level_q  <= '0;
      fetch_pc <= '0;
    end else begin
      level_q <= level_d;
      if (flush) begin
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        fetch_pc <= flush_pc;
      end else begin
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        if (push) begin
          wr_ptr   <= wr_ptr + PW'(1);
          fetch_pc <= fetch_pc + ADDR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        word_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else if (push) begin
      word_q[wr_ptr] <= mem_inst;
      pc_q[wr_ptr]   <= fetch_pc;
    end
  end

  // The head slot is never overwritten while occupied, so the outputs
  // stay stable across a stall without extra holding registers.
  assign inst_out = inst_valid ? word_q[rd_ptr] : '0;
  assign inst_pc  = inst_valid ? pc_q[rd_ptr]   : '0;
  assign mem_addr = fetch_pc;
  assign level    = level_q;

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Bench for inst_prefetch_queue: queue-based reference model checked every
// cycle, plus literal expectations at key points of a directed sequence.
module tb_inst_prefetch_queue;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;

  logic              clk;
  logic              reset;
  logic              enable;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_inst;
  logic              flush;
  logic [ADDR_W-1:0] flush_pc;
  logic [DATA_W-1:0] inst_out;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic [2:0]        level;

  int n_cmp;
  int n_bad;

  inst_prefetch_queue #(
    .DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .mem_addr(mem_addr),
    .mem_inst(mem_inst),
    .flush(flush),
    .flush_pc(flush_pc),
    .inst_out(inst_out),
    .inst_pc(inst_pc),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .level(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: memory[i] = 0x1000 + i
  assign mem_inst = 16'h1000 + {8'h00, mem_addr};

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of {word, pc} plus the fetch address.
  logic [DATA_W-1:0] mq_word [$];
  logic [ADDR_W-1:0] mq_pc   [$];
  logic [ADDR_W-1:0] m_fpc;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq_word.delete();
      mq_pc.delete();
      m_fpc = '0;
    end else if (flush) begin
      mq_word.delete();
      mq_pc.delete();
      m_fpc = flush_pc;
    end else begin
      bit p_pop, p_push;
      p_pop  = (mq_word.size() > 0) && inst_ready;
      p_push = enable && ((mq_word.size() < DEPTH) || p_pop);
      if (p_pop) begin
        void'(mq_word.pop_front());
        void'(mq_pc.pop_front());
      end
      if (p_push) begin
        mq_word.push_back(16'h1000 + {8'h00, m_fpc});
        mq_pc.push_back(m_fpc);
        m_fpc = m_fpc + 8'd1;
      end
    end
  end

  always @(negedge clk) begin
    int sz;
    sz = mq_word.size();
    check("model_mem_addr", 32'(mem_addr), 32'(m_fpc));
    check("model_valid", 32'(inst_valid), 32'(sz != 0));
    check("model_level", 32'(level), 32'(sz));
    check("model_inst_out", 32'(inst_out), sz != 0 ? 32'(mq_word[0]) : 32'h0);
    check("model_inst_pc", 32'(inst_pc), sz != 0 ? 32'(mq_pc[0]) : 32'h0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    enable = 1'b0;
    inst_ready = 1'b0;
    flush = 1'b0;
    flush_pc = '0;
    tick();
    tick();
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_valid", 32'(inst_valid), 32'h0);
    check("rst_level", 32'(level), 32'h0);
    check("rst_inst_out", 32'(inst_out), 32'h0);

    // Streaming: one word per cycle
    reset = 1'b0;
    enable = 1'b1;
    inst_ready = 1'b1;
    tick();
    check("first_word", 32'(inst_out), 32'h1000);
    check("first_pc", 32'(inst_pc), 32'h0);
    check("first_level", 32'(level), 32'h1);
    repeat (4) tick();
    check("stream_pc", 32'(inst_pc), 32'h4);
    check("stream_level", 32'(level), 32'h1);
    check("stream_addr", 32'(mem_addr), 32'h5);

    // Stall until full
    inst_ready = 1'b0;
    repeat (6) tick();
    check("full_level", 32'(level), 32'h4);
    check("full_addr", 32'(mem_addr), 32'h8);
    check("stall_word", 32'(inst_out), 32'h1004);

    // Full with simultaneous pop and push
    inst_ready = 1'b1;
    tick();
    check("fullpp_level", 32'(level), 32'h4);
    check("fullpp_addr", 32'(mem_addr), 32'h9);
    check("fullpp_pc", 32'(inst_pc), 32'h5);
    tick();
    check("fullpp_addr2", 32'(mem_addr), 32'hA);
    check("fullpp_pc2", 32'(inst_pc), 32'h6);

    // Drain one with fetch disabled, leaving level 3
    enable = 1'b0;
    tick();
    check("drain_level", 32'(level), 32'h3);
    check("drain_addr", 32'(mem_addr), 32'hA);

    // Flush to 0x40
    enable = 1'b1;
    flush = 1'b1;
    flush_pc = 8'h40;
    tick();
    check("flush_valid", 32'(inst_valid), 32'h0);
    check("flush_level", 32'(level), 32'h0);
    check("flush_addr", 32'(mem_addr), 32'h40);
    flush = 1'b0;
    tick();
    check("redir_pc", 32'(inst_pc), 32'h40);
    check("redir_word", 32'(inst_out), 32'h1040);

    // Flush to 0xFE and wrap the address
    flush = 1'b1;
    flush_pc = 8'hFE;
    tick();
    check("flush2_addr", 32'(mem_addr), 32'hFE);
    flush = 1'b0;
    tick();
    check("wrap_pc0", 32'(inst_pc), 32'hFE);
    tick();
    check("wrap_pc1", 32'(inst_pc), 32'hFF);
    check("wrap_word1", 32'(inst_out), 32'h10FF);
    tick();
    check("wrap_pc2", 32'(inst_pc), 32'h00);
    tick();
    check("wrap_pc3", 32'(inst_pc), 32'h01);

    // Build level 2, then reset asynchronously mid-cycle
    inst_ready = 1'b0;
    tick();
    check("pre_rst_level", 32'(level), 32'h2);
    #2;
    reset = 1'b1;
    #1;
    check("async_valid", 32'(inst_valid), 32'h0);
    check("async_level", 32'(level), 32'h0);
    check("async_addr", 32'(mem_addr), 32'h0);
    tick();
    reset = 1'b0;
    tick();
    check("restart_pc", 32'(inst_pc), 32'h0);
    check("restart_word", 32'(inst_out), 32'h1000);

    // Drain to empty with ready held high
    enable = 1'b0;
    inst_ready = 1'b1;
    tick();
    check("empty_level", 32'(level), 32'h0);
    tick();
    check("empty_hold", 32'(level), 32'h0);
    check("empty_valid", 32'(inst_valid), 32'h0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/inst_prefetch_queue.md
# inst_prefetch_queue

Instruction prefetch stage between the S-Machine instruction memory and the CPU decode logic. It reads sequential instruction words from the combinational instruction memory and buffers them with their addresses in a small FIFO. It hands them to the CPU over a valid/ready handshake, and discards all buffered words on a control-flow flush. This decouples instruction fetch from CPU stalls: a stalled CPU no longer freezes memory addressing, and the CPU can consume one instruction per cycle when the queue is non-empty.

## Interface
- DEPTH, 4, queue entries; power of two, 2..16
- DATA_W, 16, instruction word width
- ADDR_W, 8, instruction address width
- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- enable  input  1  fetch enable; low suppresses new fetches, draining still allowed
- mem_addr  output  ADDR_W  address driven to instruction memory (= fetch_pc register)
- mem_inst  input  DATA_W  instruction word returned combinationally for mem_addr, same cycle
- flush  input  1  discard queue and redirect fetch
- flush_pc  input  ADDR_W  new fetch address, sampled when flush=1
- inst_out  output  DATA_W  head-of-queue instruction
- inst_pc  output  ADDR_W  address of inst_out
- inst_valid  output  1  queue non-empty
- inst_ready  input  1  CPU accepts head this cycle
- level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH

## Operation
- State: fetch_pc (ADDR_W), storage of DEPTH entries {word, pc}, rd_ptr, wr_ptr ($clog2(DEPTH) bits, wrap naturally), level.
- push = enable && !flush && (level < DEPTH || pop); writes {mem_inst, fetch_pc} at wr_ptr, wr_ptr+1, fetch_pc+1.
- pop = inst_valid && inst_ready && !flush; rd_ptr+1.
- level next: +1 on push only, -1 on pop only, unchanged on both or neither.
- fetch_pc increments mod 2^ADDR_W: 0xFF -> 0x00 with no special handling.
- flush (priority over push and pop): rd_ptr, wr_ptr, level <= 0; fetch_pc <= flush_pc; no entry written that cycle; a pop asserted in the same cycle is not counted.
- inst_valid = (level != 0). inst_out/inst_pc = entry at rd_ptr when valid; forced to 0 when empty.
- inst_out/inst_pc must stay stable while inst_valid=1 and inst_ready=0.
- enable low: fetch_pc frozen, no push; pops continue until empty.
- No opcode decoding; the block is agnostic to instruction content.

## Timing
- Reset values: mem_addr=0, inst_out=0, inst_pc=0, inst_valid=0, level=0; pointers 0.
- Reset is asynchronous: assertion mid-operation clears outputs without waiting for clk. First fetch is the first rising edge with reset low and enable high.
- Fetch-to-valid latency: 1 cycle. A word pushed at edge N is visible on inst_out after edge N, with inst_valid=1.
- Steady state with inst_ready=1, enable=1: one push and one pop per cycle, level constant, one instruction per cycle delivered.
- Full (level=DEPTH): push only if pop in same cycle; otherwise fetch_pc holds.
- Empty with inst_ready=1: no pop, level stays 0.
- Flush at edge N: inst_valid=0 and mem_addr=flush_pc after edge N. First redirected word is valid after edge N+1 if enable=1.
- Flush plus reset: reset wins.

## Test plan
- Reset then enable=1, inst_ready=1, memory[i]=0x1000+i: after edge 1 inst_out=0x1000, inst_pc=0. Thereafter one word per cycle, inst_pc 0,1,2,...; level stays 1.
- inst_ready=0, enable=1 for 6 cycles: level reaches 4 after edge 4 and holds. mem_addr holds 4, inst_out=0x1000 stable. Then inst_ready=1: words 0x1000..0x1003 then 0x1004 in order, no gaps or duplicates.
- Full queue, inst_ready=1 and enable=1 same cycle: level stays 4, mem_addr advances by 1 per cycle.
- Flush with flush_pc=0x40 while level=3: inst_valid=0, level=0 after the flush edge. Next edge yields inst_pc=0x40, inst_out=memory[0x40]; no pre-flush word ever appears.
- flush_pc=0xFE, enable=1, inst_ready=1: inst_pc sequence 0xFE, 0xFF, 0x00, 0x01.
- Assert reset asynchronously mid-cycle with level=2: inst_valid, level, mem_addr go to 0 before the next clk edge. After release, fetch restarts at address 0.
